spike_extractor: RTL and testbench
==================================

SPIKE_EXTRACTOR -- requirements
Module: spike_extractor

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, feature channels per coordinate.
REQ-002 SHALL have parameter BITS_PER_CHANNEL, default 8, unsigned potential width per channel.
REQ-003 SHALL have parameters IMG_WIDTH and IMG_HEIGHT, defaults 32 and 32; pooled map scanned is OUT_W=IMG_WIDTH/2 by OUT_H=IMG_HEIGHT/2.
REQ-004 SHALL have parameter THRESHOLD, default 128, BITS_PER_CHANNEL-wide firing threshold.
REQ-005 SHALL have parameter LEAK_SHIFT, default 2, leak divisor exponent; 0 disables leak.
REQ-006 SHALL have ports: clk in 1, system clock; one clock only.
REQ-007 reset in 1, asynchronous, active-low.
REQ-008 enable in 1, start/continue scan; active out 1, high in any non-IDLE state; done out 1, one-cycle completion pulse.
REQ-009 read_req out 1; read_x out clog2(OUT_W); read_y out clog2(OUT_H); read_data in CHANNELS*BITS_PER_CHANNEL, valid exactly one cycle after read_req.
REQ-010 write_req out 1; write_x, write_y out as read_x/read_y; write_data out CHANNELS*BITS_PER_CHANNEL.
REQ-011 event_valid out 1; event_ready in 1; event_x, event_y out as read_x/read_y; event_mask out CHANNELS, bit c = channel c fired.

Function
REQ-012 FSM states IDLE, READ, EVAL, EMIT, DONE.
REQ-013 IDLE: scan coordinate = (0,0); enable high -> READ next cycle; else stay.
REQ-014 READ: enable high -> read_req=1 with current coordinate, -> EVAL; enable low -> read_req=0, coordinate held, stay in READ (pause).
REQ-015 EVAL: per channel, value >= THRESHOLD sets mask bit; write_req=1 at same coordinate, same cycle, with fired channels written 0 and others written value - (value >> LEAK_SHIFT), or value if LEAK_SHIFT=0.
REQ-016 EVAL: mask and coordinate registered into event_x/event_y/event_mask; mask nonzero -> EMIT; mask zero -> advance.
REQ-017 EMIT: event_valid=1 with stable event_x/y/mask until event_ready high in the same cycle; on handshake -> advance; no read_req while in EMIT.
REQ-018 Advance: raster order, x fastest; x=OUT_W-1 wraps x to 0 and increments y; after (OUT_W-1,OUT_H-1) -> DONE, else -> READ.
REQ-019 DONE: done=1 for exactly one cycle, coordinate cleared to (0,0), -> IDLE; enable ignored in DONE.
REQ-020 Non-firing coordinate costs exactly 2 cycles (READ, EVAL); firing coordinate costs 2 + cycles waiting in EMIT.
REQ-021 All arithmetic unsigned; leak result never underflows; no saturation needed.
REQ-022 write_req never asserted outside EVAL; read_req never asserted outside READ; read_req and write_req are never both high.

Reset
REQ-023 reset low SHALL immediately force state IDLE, coordinate (0,0), active=0, done=0, read_req=0, write_req=0, event_valid=0, event_x/y/mask=0, read/write coords and write_data=0.
REQ-024 Reset mid-scan SHALL discard any pending event; next enable restarts at (0,0).

Verification (CHANNELS=2, BITS=8, THRESHOLD=100, LEAK_SHIFT=2, IMG 4x4 -> OUT 2x2)
REQ-025 All-zero map, enable held, event_ready=1 -> 4 read_req/write_req pairs at (0,0),(1,0),(0,1),(1,1), writes 0, no event_valid, done pulses 8 cycles after first read_req.
REQ-026 (1,0) holds ch0=120, ch1=40 -> event x=1,y=0,mask=2'b01; write_data ch0=0, ch1=30.
REQ-027 ch0=100, ch1=99 -> mask=2'b01; write ch0=0, ch1=75.
REQ-028 Firing coordinate with event_ready low 5 cycles -> event_valid and event fields stable 5 cycles, no read_req; ready high -> handshake, next READ following cycle.
REQ-029 enable low 3 cycles while in READ -> read_req=0, read_x/y held, active=1; enable high -> scan resumes at same coordinate, no coordinate skipped or repeated.
REQ-030 reset asserted during EMIT -> all outputs 0 same cycle; after release and enable, first read_req at (0,0).

Source files
------------

// File: rtl/spike_if.sv
// Handshake/bus bundle between spike_extractor and its potential memory / event sink.
// Carries scan control (enable/active/done), the read/write ports of the pooled map,
//   and the event output channel with its ready.
// Ports: master = spike_extractor side, slave = memory/event-consumer side.
interface spike_if #(
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8,
  parameter int XW               = 4,
  parameter int YW               = 4
) ();
  logic                               enable;
  logic                               active;
  logic                               done;

  logic                               read_req;
  logic [XW-1:0]                      read_x;
  logic [YW-1:0]                      read_y;
  logic [CHANNELS*BITS_PER_CHANNEL-1:0] read_data;

  logic                               write_req;
  logic [XW-1:0]                      write_x;
  logic [YW-1:0]                      write_y;
  logic [CHANNELS*BITS_PER_CHANNEL-1:0] write_data;

  logic                               event_valid;
  logic                               event_ready;
  logic [XW-1:0]                      event_x;
  logic [YW-1:0]                      event_y;
  logic [CHANNELS-1:0]                event_mask;

  modport master (
    input  enable, read_data, event_ready,
    output active, done,
    output read_req, read_x, read_y,
    output write_req, write_x, write_y, write_data,
    output event_valid, event_x, event_y, event_mask
  );

  modport slave (
    output enable, read_data, event_ready,
    input  active, done,
    input  read_req, read_x, read_y,
    input  write_req, write_x, write_y, write_data,
    input  event_valid, event_x, event_y, event_mask
  );
endinterface

// File: rtl/spike_extractor.sv
// Spike extractor: raster-scans a pooled potential map, fires per-channel spikes
//   at or above THRESHOLD, writes back reset/leaked potentials and emits events.
// Ports: clk, rst_n (async active-low), bus (spike_if.master: enable/active/done,
//   read port with 1-cycle data latency, write port, event valid/ready channel).
module spike_extractor #(
  parameter int          CHANNELS         = 4,
  parameter int          BITS_PER_CHANNEL = 8,
  parameter int          IMG_WIDTH        = 32,
  parameter int          IMG_HEIGHT       = 32,
  parameter int unsigned THRESHOLD        = 128,
  parameter int          LEAK_SHIFT       = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  spike_if.master  bus
);

  localparam int OUT_W = IMG_WIDTH / 2;
  localparam int OUT_H = IMG_HEIGHT / 2;
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int B     = BITS_PER_CHANNEL;
  localparam int DW    = CHANNELS * B;
  localparam logic [B-1:0]  THR    = B'(THRESHOLD);
  localparam logic [XW-1:0] LAST_X = XW'(OUT_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(OUT_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [XW-1:0]       ev_x_q;
  logic [YW-1:0]       ev_y_q;
  logic [CHANNELS-1:0] ev_mask_q;

  logic [CHANNELS-1:0] fire;
  logic [DW-1:0]       leaked;
  logic                advance;
  logic                last_coord;
  logic                read_req;
  logic                write_req;
  logic                event_valid;
  logic                done;

  assign last_coord = (x_q == LAST_X) && (y_q == LAST_Y);

  // Per-channel threshold and write-back value. Fired channels reset to zero;
  // the rest lose value>>LEAK_SHIFT, which can never exceed value itself.
  always_comb begin
    logic [B-1:0] val;
    val    = '0;
    fire   = '0;
    leaked = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      val     = bus.read_data[c*B +: B];
      fire[c] = (val >= THR);
      if (fire[c]) begin
        leaked[c*B +: B] = '0;
      end else if (LEAK_SHIFT == 0) begin
        leaked[c*B +: B] = val;
      end else begin
        leaked[c*B +: B] = val - (val >> LEAK_SHIFT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    read_req    = 1'b0;
    write_req   = 1'b0;
    event_valid = 1'b0;
    done        = 1'b0;
    advance     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) state_d = S_READ;
      end
      S_READ: begin
        // Dropping enable here pauses the scan without losing the coordinate.
        if (bus.enable) begin
          read_req = 1'b1;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        write_req = 1'b1;
        if (|fire) state_d = S_EMIT;
        else       advance = 1'b1;
      end
      S_EMIT: begin
        event_valid = 1'b1;
        if (bus.event_ready) advance = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) state_d = last_coord ? S_DONE : S_READ;
  end

  // Scan coordinate: holds on the last position until DONE clears it, so the
  // increment never has to wrap past the map edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == S_DONE) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance && !last_coord) begin
      if (x_q == LAST_X) begin
        x_q <= '0;
        y_q <= y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_x_q    <= '0;
      ev_y_q    <= '0;
      ev_mask_q <= '0;
    end else if (state_q == S_EVAL) begin
      ev_x_q    <= x_q;
      ev_y_q    <= y_q;
      ev_mask_q <= fire;
    end
  end

  assign bus.active      = (state_q != S_IDLE);
  assign bus.done        = done;
  assign bus.read_req    = read_req;
  assign bus.read_x      = x_q;
  assign bus.read_y      = y_q;
  assign bus.write_req   = write_req;
  assign bus.write_x     = x_q;
  assign bus.write_y     = y_q;
  assign bus.write_data  = (state_q == S_EVAL) ? leaked : '0;
  assign bus.event_valid = event_valid;
  assign bus.event_x     = ev_x_q;
  assign bus.event_y     = ev_y_q;
  assign bus.event_mask  = ev_mask_q;

endmodule

// File: tb/tb_spike_extractor.sv
// Directed bench for spike_extractor on a 2x2 pooled map, 2 channels x 8 bits,
// threshold 100, leak shift 2, with a one-cycle-latency memory model.
module tb_spike_extractor;

  localparam int CH = 2;
  localparam int B  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] mem [4];
  logic [15:0] rd_q;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_if #(.CHANNELS(CH), .BITS_PER_CHANNEL(B), .XW(1), .YW(1)) sif ();

  spike_extractor #(
    .CHANNELS(CH), .BITS_PER_CHANNEL(B), .IMG_WIDTH(4), .IMG_HEIGHT(4),
    .THRESHOLD(100), .LEAK_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(sif.master)
  );

  // Memory model: data for a read request appears on the following cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else if (sif.read_req) rd_q <= mem[{sif.read_y, sif.read_x}];
  end
  assign sif.read_data = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    rst_n           = 1'b0;
    sif.enable      = 1'b0;
    sif.event_ready = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // Reset state
    #2;
    check("rst_active", sif.active, 0);
    check("rst_done", sif.done, 0);
    check("rst_read_req", sif.read_req, 0);
    check("rst_write_req", sif.write_req, 0);
    check("rst_event_valid", sif.event_valid, 0);
    check("rst_event_mask", sif.event_mask, 0);
    check("rst_read_xy", {sif.read_x, sif.read_y}, 0);
    check("rst_write_data", sif.write_data, 0);
    @(negedge clk); rst_n = 1'b1;

    // All-zero map: four read/write pairs, no events, done 8 cycles after first read
    @(negedge clk); sif.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("z_rreq%0d", i), sif.read_req, 1);
      check($sformatf("z_rxy%0d", i), {sif.read_y, sif.read_x}, i);
      check($sformatf("z_wreq_in_read%0d", i), sif.write_req, 0);
      @(negedge clk);
      check($sformatf("z_wreq%0d", i), sif.write_req, 1);
      check($sformatf("z_rreq_in_eval%0d", i), sif.read_req, 0);
      check($sformatf("z_wxy%0d", i), {sif.write_y, sif.write_x}, i);
      check($sformatf("z_wdata%0d", i), sif.write_data, 0);
      check($sformatf("z_evvld%0d", i), sif.event_valid, 0);
    end
    @(negedge clk);
    check("z_done", sif.done, 1);
    sif.enable = 1'b0;
    @(negedge clk);
    check("z_done_pulse", sif.done, 0);
    check("z_idle_active", sif.active, 0);

    // Firing patterns: (1,0)=ch0 120/ch1 40, (0,1)=100/99, (1,1)=7/200
    mem[0] = 16'h0000; mem[1] = 16'h2878; mem[2] = 16'h6364; mem[3] = 16'hC807;
    sif.enable = 1'b1;
    @(negedge clk); check("f_r00", sif.read_req, 1);
    @(negedge clk); check("f_w00", sif.write_data, 0);
    @(negedge clk); check("f_r10_xy", {sif.read_req, sif.read_y, sif.read_x}, 3'b101);
    @(negedge clk);
    check("f_w10_data", sif.write_data, 16'h1E00);
    check("f_w10_xy", {sif.write_req, sif.write_y, sif.write_x}, 3'b101);
    @(negedge clk);
    check("f_e10_vld", sif.event_valid, 1);
    check("f_e10_xy", {sif.event_y, sif.event_x}, 2'b01);
    check("f_e10_mask", sif.event_mask, 2'b01);
    check("f_e10_noread", sif.read_req, 0);
    @(negedge clk); check("f_r01_xy", {sif.read_req, sif.read_y, sif.read_x}, 3'b110);
    @(negedge clk); check("f_w01_data", sif.write_data, 16'h4B00);
    @(negedge clk);
    check("f_e01_mask", sif.event_mask, 2'b01);
    check("f_e01_xy", {sif.event_valid, sif.event_y, sif.event_x}, 3'b110);
    @(negedge clk); check("f_r11_xy", {sif.read_req, sif.read_y, sif.read_x}, 3'b111);
    @(negedge clk); check("f_w11_data", sif.write_data, 16'h0006);
    @(negedge clk);
    check("f_e11_mask", sif.event_mask, 2'b10);
    check("f_e11_xy", {sif.event_valid, sif.event_y, sif.event_x}, 3'b111);
    @(negedge clk);
    check("f_done", sif.done, 1);
    sif.enable = 1'b0;
    @(negedge clk); check("f_idle", sif.active, 0);

    // Event backpressure for 5 cycles, then a 3-cycle enable pause in READ
    mem[0] = 16'h3296; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    sif.event_ready = 1'b0;
    sif.enable      = 1'b1;
    @(negedge clk); check("s_r00", sif.read_req, 1);
    @(negedge clk); check("s_w00_data", sif.write_data, 16'h2600);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("s_hold_vld%0d", i), sif.event_valid, 1);
      check($sformatf("s_hold_fields%0d", i), {sif.event_y, sif.event_x, sif.event_mask}, 4'b0001);
      check($sformatf("s_hold_noread%0d", i), sif.read_req, 0);
      if (i == 4) sif.event_ready = 1'b1;
    end
    @(negedge clk); check("s_r10_after_hs", {sif.read_req, sif.read_y, sif.read_x}, 3'b101);
    @(negedge clk);
    check("s_w10", {sif.write_req, sif.write_y, sif.write_x}, 3'b101);
    sif.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("p_rreq%0d", i), sif.read_req, 0);
      check($sformatf("p_wreq%0d", i), sif.write_req, 0);
      check($sformatf("p_rxy%0d", i), {sif.read_y, sif.read_x}, 2'b10);
      check($sformatf("p_active%0d", i), sif.active, 1);
    end
    sif.enable = 1'b1;
    #1;
    check("p_resume_r01", {sif.read_req, sif.read_y, sif.read_x}, 3'b110);
    @(negedge clk); check("p_w01", {sif.write_req, sif.write_y, sif.write_x}, 3'b110);
    @(negedge clk); check("p_r11", {sif.read_req, sif.read_y, sif.read_x}, 3'b111);
    @(negedge clk); check("p_w11", {sif.write_req, sif.write_y, sif.write_x}, 3'b111);
    @(negedge clk);
    check("p_done", sif.done, 1);
    sif.enable = 1'b0;
    @(negedge clk);

    // Reset while an event at (1,0) is waiting in EMIT
    mem[0] = '0; mem[1] = 16'h00C8;
    sif.event_ready = 1'b0;
    sif.enable      = 1'b1;
    repeat (5) @(negedge clk);
    check("r_in_emit", {sif.event_valid, sif.event_y, sif.event_x, sif.event_mask}, 5'b10101);
    rst_n      = 1'b0;
    sif.enable = 1'b0;
    #1;
    check("r_evvld", sif.event_valid, 0);
    check("r_evfields", {sif.event_y, sif.event_x, sif.event_mask}, 0);
    check("r_active", sif.active, 0);
    check("r_rwxy", {sif.read_y, sif.read_x, sif.write_y, sif.write_x}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sif.event_ready = 1'b1;
    mem[1] = '0;
    @(negedge clk); sif.enable = 1'b1;
    @(negedge clk);
    check("r_restart_r00", {sif.read_req, sif.read_y, sif.read_x}, 3'b100);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sif.done) begin
        got = 1'b1;
        break;
      end
    end
    check("r_scan_done", got, 1);
    sif.enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
